// File: rtl/ahb_mtx_pkg.sv
// ahb_mtx_pkg: shared AHB encodings and input-stage FSM states for the bus matrix.
package ahb_mtx_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PEND = 2'd1,
        S_DATA = 2'd2
    } in_stg_state_t;

    // NONSEQ or SEQ: the only transfer types that ask for a slave.
    function automatic logic is_active(input logic [1:0] t);
        return (t != HTRANS_IDLE) && (t != HTRANS_BUSY);
    endfunction

endpackage

// File: rtl/ahb_mtx_in_stg_hold.sv
// ahb_mtx_in_stg_hold: address-phase capture bank and held/live mux toward the output stages.
//  Inputs : HCLK, HRESET (async, active-high), i_cap (load hold regs), i_use_hold (drive held values),
//           i_sel (live select, forces IDLE when low), live address-phase fields i_*.
//  Outputs: o_* address-phase fields toward the output stages.
module ahb_mtx_in_stg_hold
    import ahb_mtx_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              i_cap,
    input  logic              i_use_hold,
    input  logic              i_sel,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [1:0]        i_trans,
    input  logic              i_write,
    input  logic [2:0]        i_size,
    input  logic [2:0]        i_burst,
    input  logic [3:0]        i_prot,
    input  logic              i_lock,
    output logic [ADDR_W-1:0] o_addr,
    output logic [1:0]        o_trans,
    output logic              o_write,
    output logic [2:0]        o_size,
    output logic [2:0]        o_burst,
    output logic [3:0]        o_prot,
    output logic              o_lock
);

    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_trans;
    logic              r_write;
    logic [2:0]        r_size;
    logic [2:0]        r_burst;
    logic [3:0]        r_prot;
    logic              r_lock;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_addr  <= '0;
            r_trans <= HTRANS_IDLE;
            r_write <= 1'b0;
            r_size  <= '0;
            r_burst <= '0;
            r_prot  <= '0;
            r_lock  <= 1'b0;
        end else if (i_cap) begin
            r_addr  <= i_addr;
            r_trans <= i_trans;
            r_write <= i_write;
            r_size  <= i_size;
            r_burst <= i_burst;
            r_prot  <= i_prot;
            r_lock  <= i_lock;
        end
    end

    assign o_addr  = i_use_hold ? r_addr  : i_addr;
    assign o_trans = i_use_hold ? r_trans : (i_sel ? i_trans : HTRANS_IDLE);
    assign o_write = i_use_hold ? r_write : i_write;
    assign o_size  = i_use_hold ? r_size  : i_size;
    assign o_burst = i_use_hold ? r_burst : i_burst;
    assign o_prot  = i_use_hold ? r_prot  : i_prot;
    assign o_lock  = i_use_hold ? r_lock  : i_lock;

endmodule

// File: rtl/ahb_mtx_in_stg.sv
// ahb_mtx_in_stg: bus-matrix master-port input stage; buffers ungranted address phases and returns slave response.
//  Master side : HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS, HREADYS in;
//                HREADYOUTS, HRESPS out.
//  Matrix side : HADDRI, HTRANSI, HWRITEI, HSIZEI, HBURSTI, HPROTI, HMASTLOCKI, trans_pend out;
//                active_ph, readyout_dp, resp_dp in.
//  Monitor     : starve_flag out, built only when AHBMTX_STARVE_MON_EN is defined (else tied 0).
module ahb_mtx_in_stg
    import ahb_mtx_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int CNT_W        = 8,
    parameter int STARVE_LIMIT = 64
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSELS,
    input  logic [ADDR_W-1:0] HADDRS,
    input  logic [1:0]        HTRANSS,
    input  logic              HWRITES,
    input  logic [2:0]        HSIZES,
    input  logic [2:0]        HBURSTS,
    input  logic [3:0]        HPROTS,
    input  logic              HMASTLOCKS,
    input  logic              HREADYS,
    output logic              HREADYOUTS,
    output logic              HRESPS,
    output logic [ADDR_W-1:0] HADDRI,
    output logic [1:0]        HTRANSI,
    output logic              HWRITEI,
    output logic [2:0]        HSIZEI,
    output logic [2:0]        HBURSTI,
    output logic [3:0]        HPROTI,
    output logic              HMASTLOCKI,
    output logic              trans_pend,
    input  logic              active_ph,
    input  logic              readyout_dp,
    input  logic              resp_dp,
    output logic              starve_flag
);

    in_stg_state_t r_state, w_nxt;
    logic w_new_tr, w_free, w_cap;

    assign w_new_tr = HSELS & HREADYS & is_active(HTRANSS);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) r_state <= S_IDLE;
        else        r_state <= w_nxt;
    end

    // w_free: the stage can take a new address phase this cycle (idle, or own data phase completing).
    always_comb begin
        w_free = (r_state == S_IDLE) | ((r_state == S_DATA) & readyout_dp);
        w_cap  = w_free & w_new_tr & ~active_ph;
        w_nxt  = w_free ? (w_new_tr ? (active_ph ? S_DATA : S_PEND) : S_IDLE)
               : ((r_state == S_PEND) & active_ph) ? S_DATA : r_state;
    end

    // Reset gates the live request and transfer type so the arbiters see nothing while HRESET is high.
    ahb_mtx_in_stg_hold #(.ADDR_W(ADDR_W)) u_hold (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .i_cap      (w_cap),
        .i_use_hold (r_state == S_PEND),
        .i_sel      (HSELS & ~HRESET),
        .i_addr     (HADDRS),
        .i_trans    (HTRANSS),
        .i_write    (HWRITES),
        .i_size     (HSIZES),
        .i_burst    (HBURSTS),
        .i_prot     (HPROTS),
        .i_lock     (HMASTLOCKS),
        .o_addr     (HADDRI),
        .o_trans    (HTRANSI),
        .o_write    (HWRITEI),
        .o_size     (HSIZEI),
        .o_burst    (HBURSTI),
        .o_prot     (HPROTI),
        .o_lock     (HMASTLOCKI)
    );

    assign trans_pend = ~HRESET & ((r_state == S_PEND) | (HSELS & is_active(HTRANSS)));
    assign HREADYOUTS = (r_state == S_DATA) ? readyout_dp : (r_state != S_PEND);
    assign HRESPS     = (r_state == S_DATA) ? resp_dp : HRESP_OKAY;

`ifdef AHBMTX_STARVE_MON_EN
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_starve;

    assign w_cnt_nxt = (r_state != S_PEND) ? '0 : (&r_cnt) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_cnt    <= '0;
            r_starve <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_starve <= 32'(w_cnt_nxt) >= STARVE_LIMIT;
        end
    end

    assign starve_flag = r_starve;
`else
    assign starve_flag = 1'b0 & (CNT_W > 0) & (STARVE_LIMIT > 0);
`endif

endmodule
